cache_fill_ctrl: RTL and testbench

- Producer stage for the packed cache data array consumed by the cache lookup/compare block.
- Performs burst line fills from a memory return stream into consecutive cache entries, with wrap-around.
- Also accepts single-entry direct writes and tracks a per-entry valid bit.
- Drives cache_mem and line_valid as registered outputs.

---
 rtl/cache_fill_ctrl_if.sv | 36 +++
 rtl/cache_fill_ctrl.sv | 116 +++++++++++
 tb/tb_cache_fill_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Signal bundle between a cache fill controller and whoever drives fills,
// memory returns and direct writes. The controller side is the slave.
interface cache_fill_ctrl_if #(
  parameter int CACHE_SIZE     = 8,
  parameter int MEM_DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(CACHE_SIZE);

  logic                                          fill_req;
  logic [IDX_W-1:0]                              fill_base;
  logic [IDX_W:0]                                fill_len;
  logic                                          mem_rd;
  logic                                          mem_rvalid;
  logic [MEM_DATA_WIDTH-1:0]                     mem_rdata;
  logic                                          wr_en;
  logic [IDX_W-1:0]                              wr_idx;
  logic [MEM_DATA_WIDTH-1:0]                     wr_data;
  logic                                          inv_all;
  logic                                          busy;
  logic                                          done;
  logic                                          err;
  logic [CACHE_SIZE-1:0][MEM_DATA_WIDTH-1:0]     cache_mem;
  logic [CACHE_SIZE-1:0]                         line_valid;

  modport master (
    output fill_req, fill_base, fill_len, mem_rvalid, mem_rdata,
           wr_en, wr_idx, wr_data, inv_all,
    input  mem_rd, busy, done, err, cache_mem, line_valid
  );

  modport slave (
    input  fill_req, fill_base, fill_len, mem_rvalid, mem_rdata,
           wr_en, wr_idx, wr_data, inv_all,
    output mem_rd, busy, done, err, cache_mem, line_valid
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Burst line-fill controller: writes a memory return stream into consecutive
// (wrapping) cache entries, plus direct single-entry writes and valid tracking.
module cache_fill_ctrl #(
  parameter int CACHE_SIZE     = 8,
  parameter int MEM_DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_fill_ctrl_if.slave       bus
);
  localparam int             IDX_W   = $clog2(CACHE_SIZE);
  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(CACHE_SIZE);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                                    state, state_nxt;
  logic [IDX_W-1:0]                          base_q;
  logic [IDX_W:0]                            len_q;
  logic [IDX_W:0]                            cnt;
  logic [IDX_W-1:0]                          fill_idx;
  logic                                      fill_we;
  logic                                      wr_drop;
  logic                                      len_bad;
  logic                                      start;
  logic                                      err_nxt;
  logic                                      mem_rd_q, busy_q, done_q, err_q;
  logic [CACHE_SIZE-1:0][MEM_DATA_WIDTH-1:0] mem_q, mem_nxt;
  logic [CACHE_SIZE-1:0]                     valid_q, valid_nxt;

  assign fill_idx = base_q + cnt[IDX_W-1:0];
  assign fill_we  = (state == FILL) && bus.mem_rvalid;
  assign wr_drop  = fill_we && bus.wr_en && (bus.wr_idx == fill_idx);
  assign len_bad  = (bus.fill_len == '0) || (bus.fill_len > MAX_LEN);
  assign start    = (state == IDLE) && bus.fill_req && !len_bad;

  always_comb begin
    state_nxt = state;
    err_nxt   = wr_drop;
    case (state)
      IDLE: begin
        if (bus.fill_req) begin
          if (len_bad) err_nxt = 1'b1;
          else         state_nxt = FILL;
        end
      end
      FILL: begin
        if (fill_we && (cnt == len_q - ONE)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Status outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      cnt      <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (start) begin
        base_q <= bus.fill_base;
        len_q  <= bus.fill_len;
        cnt    <= '0;
      end else if (fill_we) begin
        cnt <= cnt + ONE;
      end
      mem_rd_q <= (state_nxt == FILL);
      busy_q   <= (state_nxt != IDLE);
      done_q   <= (state_nxt == DONE);
      err_q    <= err_nxt;
    end
  end

  // Fill write is applied last so it overrides a colliding direct write,
  // and bit sets come after inv_all so a set wins over the clear.
  always_comb begin
    mem_nxt   = mem_q;
    valid_nxt = bus.inv_all ? '0 : valid_q;
    if (bus.wr_en && !wr_drop) begin
      mem_nxt[bus.wr_idx]   = bus.wr_data;
      valid_nxt[bus.wr_idx] = 1'b1;
    end
    if (fill_we) begin
      mem_nxt[fill_idx]   = bus.mem_rdata;
      valid_nxt[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      valid_q <= '0;
    end else begin
      mem_q   <= mem_nxt;
      valid_q <= valid_nxt;
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.cache_mem  = mem_q;
  assign bus.line_valid = valid_q;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios then random traffic, with a
// queue of expected per-cycle outputs drained by an independent monitor.
module tb_cache_fill_ctrl;
  localparam int CS = 8;
  localparam int DW = 8;
  localparam int IW = $clog2(CS);
  localparam int WW = CS * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cache_fill_ctrl_if #(.CACHE_SIZE(CS), .MEM_DATA_WIDTH(DW)) bus ();

  cache_fill_ctrl #(.CACHE_SIZE(CS), .MEM_DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                      err;
    logic                      done;
    logic                      busy;
    logic                      memRd;
    logic [CS-1:0][DW-1:0]     mem;
    logic [CS-1:0]             valid;
  } expect_t;

  expect_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference model: entry contents, valid bits, words still owed by the
  // current burst, the next entry to fill and whether the done cycle is due.
  logic [DW-1:0] mMem [CS];
  logic [CS-1:0] mValid;
  int            owed;
  int            fillPtr;
  bit            inDone;

  task automatic modelReset();
    for (int i = 0; i < CS; i++) mMem[i] = '0;
    mValid  = '0;
    owed    = 0;
    fillPtr = 0;
    inDone  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                             input logic [WW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic driveIdleInputs();
    bus.fill_req   = 1'b0;
    bus.fill_base  = '0;
    bus.fill_len   = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.wr_en      = 1'b0;
    bus.wr_idx     = '0;
    bus.wr_data    = '0;
    bus.inv_all    = 1'b0;
  endtask

  task automatic applyStimulus(input bit freq, input int base, input int len,
                               input bit rv, input logic [DW-1:0] rd,
                               input bit we, input int widx, input logic [DW-1:0] wd,
                               input bit inv);
    expect_t e;
    int      fidx;
    bit      wasIdle;
    @(negedge clk);
    bus.fill_req   = freq;
    bus.fill_base  = IW'(base);
    bus.fill_len   = (IW+1)'(len);
    bus.mem_rvalid = rv;
    bus.mem_rdata  = rd;
    bus.wr_en      = we;
    bus.wr_idx     = IW'(widx);
    bus.wr_data    = wd;
    bus.inv_all    = inv;

    wasIdle = (owed == 0) && !inDone;
    fidx    = (owed > 0 && rv) ? fillPtr : -1;
    e.err   = 1'b0;
    if (inv) mValid = '0;
    if (we) begin
      if (widx == fidx) e.err = 1'b1;
      else begin
        mMem[widx]   = wd;
        mValid[widx] = 1'b1;
      end
    end
    if (fidx >= 0) begin
      mMem[fidx]   = rd;
      mValid[fidx] = 1'b1;
      fillPtr      = (fillPtr + 1) % CS;
      owed--;
    end
    inDone = (fidx >= 0) && (owed == 0);
    if (wasIdle && freq) begin
      if (len < 1 || len > CS) e.err = 1'b1;
      else begin
        owed    = len;
        fillPtr = base;
      end
    end
    e.done  = inDone;
    e.busy  = (owed > 0) || inDone;
    e.memRd = (owed > 0);
    for (int i = 0; i < CS; i++) e.mem[i] = mMem[i];
    e.valid = mValid;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic burst(input int base, input int len, input logic [DW-1:0] firstData);
    applyStimulus(1, base, len, 0, '0, 0, 0, '0, 0);
    for (int i = 0; i < len; i++)
      applyStimulus(0, 0, 0, 1, firstData + DW'(i), 0, 0, '0, 0);
  endtask

  task automatic checkAllZero();
    checkOutput("rst_err",        WW'(bus.err),        '0);
    checkOutput("rst_done",       WW'(bus.done),       '0);
    checkOutput("rst_busy",       WW'(bus.busy),       '0);
    checkOutput("rst_mem_rd",     WW'(bus.mem_rd),     '0);
    checkOutput("rst_cache_mem",  WW'(bus.cache_mem),  '0);
    checkOutput("rst_line_valid", WW'(bus.line_valid), '0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    driveIdleInputs();
    rst_n = 1'b0;
    #1;
    checkAllZero();
    modelReset();
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("err",        WW'(bus.err),        WW'(e.err));
        checkOutput("done",       WW'(bus.done),       WW'(e.done));
        checkOutput("busy",       WW'(bus.busy),       WW'(e.busy));
        checkOutput("mem_rd",     WW'(bus.mem_rd),     WW'(e.memRd));
        checkOutput("cache_mem",  WW'(bus.cache_mem),  WW'(e.mem));
        checkOutput("line_valid", WW'(bus.line_valid), WW'(e.valid));
      end
    end
  end

  initial begin : stimulus
    bit gap [6] = '{1, 0, 1, 1, 0, 1};
    logic [DW-1:0] d;
    driveIdleInputs();
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkAllZero();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic burst base=0 len=4");
    burst(0, 4, 8'hA0);
    idle(3);

    $display("[TB] wrapping burst with stalls");
    applyStimulus(1, 6, 4, 0, '0, 0, 0, '0, 0);
    d = 8'h10;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, gap[i], gap[i] ? d : 8'hFF, 0, 0, '0, 0);
      if (gap[i]) d++;
    end
    idle(3);

    $display("[TB] illegal lengths");
    applyStimulus(1, 3, 0, 0, '0, 0, 0, '0, 0);
    idle(2);
    applyStimulus(1, 3, 9, 0, '0, 0, 0, '0, 0);
    idle(2);

    $display("[TB] direct write collisions during fill");
    applyStimulus(1, 2, 3, 0, '0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 8'h55, 1, 2, 8'hEE, 0);
    applyStimulus(0, 0, 0, 1, 8'h56, 1, 5, 8'h77, 0);
    applyStimulus(0, 0, 0, 1, 8'h57, 0, 0, '0, 0);
    idle(3);

    $display("[TB] full fill then inv_all alongside a fill write");
    burst(0, 8, 8'hC0);
    idle(2);
    applyStimulus(1, 2, 1, 0, '0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 8'h99, 0, 0, '0, 1);
    idle(3);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1, 0, 4, 0, '0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 8'h31, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, 1, 8'h32, 0, 0, '0, 0);
    applyReset();
    burst(1, 2, 8'h40);
    idle(3);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      int len;
      len = ($urandom % 10 == 0) ? (($urandom % 2) ? 9 : 0) : int'($urandom_range(1, CS));
      applyStimulus($urandom % 6 == 0, int'($urandom % CS), len,
                    $urandom % 4 != 0, DW'($urandom),
                    $urandom % 5 == 0, int'($urandom % CS), DW'($urandom),
                    $urandom % 16 == 0);
    end
    idle(3);

    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
